iso7816_pps_analyzer: RTL and testbench
=======================================

# iso7816_pps_analyzer

Passive monitor for the ISO 7816-3 PPS exchange that may follow the ATR. It consumes the convention-corrected byte stream and byte direction produced by the T=0 analyzer's receive path. It parses the terminal's PPS request and the card's PPS response, checks both, and reports the negotiated Fi/Di codes and protocol. On success it pulses an update strobe so the Fi/Di source can switch the ETU.

## Interface
Parameters:
- none

Ports:
- isoClk  in  1  ISO clock; all logic on its rising edge
- nReset  in  1  asynchronous, active-low reset
- restart  in  1  synchronous clear (deactivation or warm reset); returns to IDLE and clears status
- enable  in  1  high while a PPS may start (ATR completed, no TPDU header seen yet)
- byteValid  in  1  one-cycle pulse per received byte (endOfRx)
- byteData  in  8  received byte, already convention-corrected
- byteFromCard  in  1  1 = byte sent by card, 0 = sent by terminal; sampled with byteValid
- cyclesPerEtu  in  13  current ETU length in isoClk cycles; used only with the timeout feature
- ppsActive  out  1  exchange in progress (any state other than IDLE/DONE/ERROR)
- ppsDone  out  1  exchange accepted; held
- ppsError  out  1  exchange failed; held
- errCode  out  3  failure cause, valid while ppsError
- negFiCode  out  4  negotiated Fi code
- negDiCode  out  4  negotiated Di code
- negProtocol  out  4  protocol T from the request PPS0
- fiDiUpdate  out  1  one-cycle strobe on acceptance

## Operation
- Reset values: ppsActive=0, ppsDone=0, ppsError=0, errCode=0, negFiCode=4'h1, negDiCode=4'h1, negProtocol=0, fiDiUpdate=0, state IDLE, pck accumulator 0.
- States: IDLE, REQ_PPS0, REQ_PPS1, REQ_PPS2, REQ_PPS3, REQ_PCK, RSP_PPSS, RSP_PPS0, RSP_PPS1, RSP_PPS2, RSP_PPS3, RSP_PCK, DONE, ERROR.
- All transitions occur only on byteValid, except restart and timeout.
- In IDLE, the trigger is byteValid & enable & ~byteFromCard & byteData==8'hFF. On trigger: go to REQ_PPS0 and set the accumulator to FF. Any other byte leaves IDLE unchanged.
- REQ_PPS0:
  - bit7 must be 0, else error 1.
  - Store T = bits[3:0] and presence mask = bits[6:4].
  - Next state is the first present of PPS1/2/3, or REQ_PCK if none are present.
- PPSx states store the byte and advance to the next present byte.
- The accumulator XORs every byte.
- REQ_PCK: the accumulator after XOR must equal 0, else error 2. On success, clear the accumulator and go to RSP_PPSS.
- RSP_PPSS: byte must be FF, else error 3.
- RSP_PPS0:
  - bits[3:0] must equal the request T.
  - Response presence bits must be a subset of the request presence bits.
  - bit7 must be 0.
  - Any violation gives error 5.
- RSP_PPS1: if present, it must equal the request PPS1, else error 5.
- RSP_PPS2/3: if present, each must equal its request byte, else error 5.
- RSP_PCK: the XOR must be 0, else error 4. On success go to DONE.
- Direction rule:
  - A card byte in any REQ_* state gives error 6.
  - A terminal byte in any RSP_* state gives error 6.
- DONE:
  - ppsDone=1.
  - negProtocol = request T.
  - If the response PPS1 is present: negFiCode/negDiCode = PPS1[7:4]/[3:0].
  - Otherwise both stay 1/1.
- ERROR: ppsError=1 and errCode is latched. Negotiated outputs are unchanged from their prior values.
- DONE and ERROR are terminal until restart. Bytes received in either state are ignored.
- restart has priority over a simultaneous byteValid: the next state is IDLE and all outputs return to their reset values.
- Error codes: 1 reserved bit, 2 request PCK, 3 response PPSS, 4 response PCK, 5 mismatch, 6 direction, 7 timeout. Only the first error is latched.

## Timing
- Outputs are registered.
- State, ppsDone, ppsError, errCode and negotiated values update on the isoClk edge that samples byteValid=1. They are visible the following cycle.
- fiDiUpdate is high for exactly one cycle, coincident with the first cycle ppsDone=1.
- ppsActive rises the cycle after the PPSS trigger. It falls when DONE or ERROR is entered.
- Zero added latency beyond that one register stage. Back-to-back byteValid pulses on consecutive cycles must be handled.

## Configuration
- PPS_TIMEOUT_EN defined:
  - An ETU prescaler counts isoClk up to cyclesPerEtu-1 and emits an ETU tick.
  - A 14-bit ETU counter is active in RSP_PPSS through RSP_PCK and is cleared on every byteValid.
  - When the counter reaches 9600, go to ERROR with errCode 7.
  - byteValid on the same cycle as the timeout wins; no error is raised.
- PPS_TIMEOUT_EN undefined: the counter logic is absent, cyclesPerEtu is ignored, and errCode 7 is never produced. RSP states wait indefinitely.

## Test plan
- Terminal sends FF 10 95 7A, card returns FF 10 95 7A -> ppsDone=1, negFiCode=9, negDiCode=5, negProtocol=0, fiDiUpdate high exactly one cycle.
- Terminal sends FF 10 95 7A, card returns FF 00 FF -> ppsDone=1, negFiCode=1, negDiCode=1.
- Terminal sends FF 10 95 7B -> ppsError=1, errCode=2 the cycle after the 4th byte; no further state change on later bytes.
- Terminal sends FF 10 95 7A, card returns FF 11 95 7B -> ppsError=1, errCode=5 after the response PPS0.
- Card-direction byte 3B after terminal FF -> errCode=6. Then assert restart together with byteValid -> all outputs return to their reset values, state IDLE.
- With PPS_TIMEOUT_EN, cyclesPerEtu=1, and the request completed with no response -> errCode=7 after 9600 cycles (±1). Without the macro -> ppsActive stays 1 and ppsError stays 0.

Source files
------------

// File: rtl/iso7816_pps_analyzer.sv
// ISO 7816-3 PPS exchange monitor: parses request/response, reports negotiated Fi/Di/T.
// Optional response timeout enabled by defining PPS_TIMEOUT_EN.
module iso7816_pps_analyzer (
  input  logic        isoClk,
  input  logic        nReset,
  input  logic        restart,
  input  logic        enable,
  input  logic        byteValid,
  input  logic [7:0]  byteData,
  input  logic        byteFromCard,
  input  logic [12:0] cyclesPerEtu,
  output logic        ppsActive,
  output logic        ppsDone,
  output logic        ppsError,
  output logic [2:0]  errCode,
  output logic [3:0]  negFiCode,
  output logic [3:0]  negDiCode,
  output logic [3:0]  negProtocol,
  output logic        fiDiUpdate
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_REQ_PPS0,
    S_REQ_PPS1,
    S_REQ_PPS2,
    S_REQ_PPS3,
    S_REQ_PCK,
    S_RSP_PPSS,
    S_RSP_PPS0,
    S_RSP_PPS1,
    S_RSP_PPS2,
    S_RSP_PPS3,
    S_RSP_PCK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  w_err;
  logic [7:0]  w_pckNext;
  logic        w_isReq;
  logic        w_isRsp;
  logic        w_timeout;
  logic        w_enterDone;
  logic        w_enterErr;

  logic [7:0]  r_pck;
  logic [3:0]  r_reqT;
  logic [2:0]  r_reqMask;
  logic [7:0]  r_reqPps1;
  logic [7:0]  r_reqPps2;
  logic [7:0]  r_reqPps3;
  logic [2:0]  r_rspMask;
  logic [7:0]  r_rspPps1;
  logic [2:0]  r_errCode;
  logic [3:0]  r_negFi;
  logic [3:0]  r_negDi;
  logic [3:0]  r_negT;
  logic        r_fiDiUpdate;

  // Next present optional byte; mask bit0=PPS1, bit1=PPS2, bit2=PPS3
  function automatic state_t f_req(input logic [2:0] m);
    if (m[0])      f_req = S_REQ_PPS1;
    else if (m[1]) f_req = S_REQ_PPS2;
    else if (m[2]) f_req = S_REQ_PPS3;
    else           f_req = S_REQ_PCK;
  endfunction

  function automatic state_t f_rsp(input logic [2:0] m);
    if (m[0])      f_rsp = S_RSP_PPS1;
    else if (m[1]) f_rsp = S_RSP_PPS2;
    else if (m[2]) f_rsp = S_RSP_PPS3;
    else           f_rsp = S_RSP_PCK;
  endfunction

  assign w_isReq = (r_state == S_REQ_PPS0) || (r_state == S_REQ_PPS1) ||
                   (r_state == S_REQ_PPS2) || (r_state == S_REQ_PPS3) ||
                   (r_state == S_REQ_PCK);
  assign w_isRsp = (r_state == S_RSP_PPSS) || (r_state == S_RSP_PPS0) ||
                   (r_state == S_RSP_PPS1) || (r_state == S_RSP_PPS2) ||
                   (r_state == S_RSP_PPS3) || (r_state == S_RSP_PCK);
  assign w_pckNext = r_pck ^ byteData;

`ifdef PPS_TIMEOUT_EN
  logic [12:0] r_presc;
  logic [13:0] r_etuCnt;
  logic        w_tick;

  assign w_tick = ({1'b0, r_presc} + 14'd1) >= {1'b0, cyclesPerEtu};
  assign w_timeout = w_isRsp && (r_etuCnt == 14'd9600);

  always_ff @(posedge isoClk or negedge nReset) begin
    if (!nReset) begin
      r_presc  <= '0;
      r_etuCnt <= '0;
    end else if (restart) begin
      r_presc  <= '0;
      r_etuCnt <= '0;
    end else begin
      r_presc <= w_tick ? 13'd0 : r_presc + 13'd1;
      if (byteValid || !w_isRsp)
        r_etuCnt <= '0;
      else if (w_tick && r_etuCnt != 14'd9600)
        r_etuCnt <= r_etuCnt + 14'd1;
    end
  end
`else
  logic w_unused;
  assign w_unused  = ^cyclesPerEtu;
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge isoClk or negedge nReset) begin
    if (!nReset)      r_state <= S_IDLE;
    else if (restart) r_state <= S_IDLE;
    else              r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_err  = 3'd0;
    if (byteValid) begin
      if (w_isReq && byteFromCard) begin
        w_next = S_ERROR;
        w_err  = 3'd6;
      end else if (w_isRsp && !byteFromCard) begin
        w_next = S_ERROR;
        w_err  = 3'd6;
      end else begin
        case (r_state)
          S_IDLE:
            if (enable && !byteFromCard && byteData == 8'hFF)
              w_next = S_REQ_PPS0;
          S_REQ_PPS0:
            if (byteData[7]) begin
              w_next = S_ERROR;
              w_err  = 3'd1;
            end else begin
              w_next = f_req(byteData[6:4]);
            end
          S_REQ_PPS1: w_next = f_req(r_reqMask & 3'b110);
          S_REQ_PPS2: w_next = f_req(r_reqMask & 3'b100);
          S_REQ_PPS3: w_next = S_REQ_PCK;
          S_REQ_PCK:
            if (w_pckNext != 8'h00) begin
              w_next = S_ERROR;
              w_err  = 3'd2;
            end else begin
              w_next = S_RSP_PPSS;
            end
          S_RSP_PPSS:
            if (byteData != 8'hFF) begin
              w_next = S_ERROR;
              w_err  = 3'd3;
            end else begin
              w_next = S_RSP_PPS0;
            end
          S_RSP_PPS0:
            if (byteData[7] || byteData[3:0] != r_reqT ||
                (|(byteData[6:4] & ~r_reqMask))) begin
              w_next = S_ERROR;
              w_err  = 3'd5;
            end else begin
              w_next = f_rsp(byteData[6:4]);
            end
          S_RSP_PPS1:
            if (byteData != r_reqPps1) begin
              w_next = S_ERROR;
              w_err  = 3'd5;
            end else begin
              w_next = f_rsp(r_rspMask & 3'b110);
            end
          S_RSP_PPS2:
            if (byteData != r_reqPps2) begin
              w_next = S_ERROR;
              w_err  = 3'd5;
            end else begin
              w_next = f_rsp(r_rspMask & 3'b100);
            end
          S_RSP_PPS3:
            if (byteData != r_reqPps3) begin
              w_next = S_ERROR;
              w_err  = 3'd5;
            end else begin
              w_next = S_RSP_PCK;
            end
          S_RSP_PCK:
            if (w_pckNext != 8'h00) begin
              w_next = S_ERROR;
              w_err  = 3'd4;
            end else begin
              w_next = S_DONE;
            end
          default: w_next = r_state;
        endcase
      end
    end else if (w_timeout) begin
      w_next = S_ERROR;
      w_err  = 3'd7;
    end
  end

  assign w_enterDone = (w_next == S_DONE) && (r_state != S_DONE);
  assign w_enterErr  = (w_next == S_ERROR) && (r_state != S_ERROR);

  always_ff @(posedge isoClk or negedge nReset) begin
    if (!nReset) begin
      r_pck        <= '0;
      r_reqT       <= '0;
      r_reqMask    <= '0;
      r_reqPps1    <= '0;
      r_reqPps2    <= '0;
      r_reqPps3    <= '0;
      r_rspMask    <= '0;
      r_rspPps1    <= '0;
      r_errCode    <= '0;
      r_negFi      <= 4'h1;
      r_negDi      <= 4'h1;
      r_negT       <= '0;
      r_fiDiUpdate <= 1'b0;
    end else if (restart) begin
      r_pck        <= '0;
      r_reqT       <= '0;
      r_reqMask    <= '0;
      r_reqPps1    <= '0;
      r_reqPps2    <= '0;
      r_reqPps3    <= '0;
      r_rspMask    <= '0;
      r_rspPps1    <= '0;
      r_errCode    <= '0;
      r_negFi      <= 4'h1;
      r_negDi      <= 4'h1;
      r_negT       <= '0;
      r_fiDiUpdate <= 1'b0;
    end else begin
      r_fiDiUpdate <= w_enterDone;
      if (w_enterErr)
        r_errCode <= w_err;
      if (w_enterDone) begin
        r_negT <= r_reqT;
        if (r_rspMask[0]) begin
          r_negFi <= r_rspPps1[7:4];
          r_negDi <= r_rspPps1[3:0];
        end
      end
      if (byteValid) begin
        case (r_state)
          S_IDLE:
            if (w_next == S_REQ_PPS0)
              r_pck <= 8'hFF;
          S_REQ_PPS0: begin
            r_pck     <= w_pckNext;
            r_reqT    <= byteData[3:0];
            r_reqMask <= byteData[6:4];
          end
          S_REQ_PPS1: begin
            r_pck     <= w_pckNext;
            r_reqPps1 <= byteData;
          end
          S_REQ_PPS2: begin
            r_pck     <= w_pckNext;
            r_reqPps2 <= byteData;
          end
          S_REQ_PPS3: begin
            r_pck     <= w_pckNext;
            r_reqPps3 <= byteData;
          end
          // Response check value restarts from zero and covers its own PPSS
          S_REQ_PCK: r_pck <= 8'h00;
          S_RSP_PPS0: begin
            r_pck     <= w_pckNext;
            r_rspMask <= byteData[6:4];
          end
          S_RSP_PPS1: begin
            r_pck     <= w_pckNext;
            r_rspPps1 <= byteData;
          end
          S_RSP_PPSS, S_RSP_PPS2, S_RSP_PPS3, S_RSP_PCK:
            r_pck <= w_pckNext;
          default: r_pck <= r_pck;
        endcase
      end
    end
  end

  always_comb begin
    ppsActive   = (r_state != S_IDLE) && (r_state != S_DONE) &&
                  (r_state != S_ERROR);
    ppsDone     = (r_state == S_DONE);
    ppsError    = (r_state == S_ERROR);
    errCode     = r_errCode;
    negFiCode   = r_negFi;
    negDiCode   = r_negDi;
    negProtocol = r_negT;
    fiDiUpdate  = r_fiDiUpdate;
  end

endmodule

// File: tb/tb_iso7816_pps_analyzer.sv
// Scoreboard bench for iso7816_pps_analyzer.
// Expected outcomes are queued per exchange and compared when done/error appears.
module tb_iso7816_pps_analyzer;

  logic        isoClk;
  logic        nReset;
  logic        restart;
  logic        enable;
  logic        byteValid;
  logic [7:0]  byteData;
  logic        byteFromCard;
  logic [12:0] cyclesPerEtu;
  logic        ppsActive;
  logic        ppsDone;
  logic        ppsError;
  logic [2:0]  errCode;
  logic [3:0]  negFiCode;
  logic [3:0]  negDiCode;
  logic [3:0]  negProtocol;
  logic        fiDiUpdate;

  typedef struct {
    logic       done;
    logic       err;
    logic [2:0] code;
    logic [3:0] fi;
    logic [3:0] di;
    logic [3:0] prot;
  } exp_t;

  exp_t q_exp[$];
  int   n_chk;
  int   n_fail;

  iso7816_pps_analyzer u_dut (
    .isoClk       (isoClk),
    .nReset       (nReset),
    .restart      (restart),
    .enable       (enable),
    .byteValid    (byteValid),
    .byteData     (byteData),
    .byteFromCard (byteFromCard),
    .cyclesPerEtu (cyclesPerEtu),
    .ppsActive    (ppsActive),
    .ppsDone      (ppsDone),
    .ppsError     (ppsError),
    .errCode      (errCode),
    .negFiCode    (negFiCode),
    .negDiCode    (negDiCode),
    .negProtocol  (negProtocol),
    .fiDiUpdate   (fiDiUpdate)
  );

  initial isoClk = 1'b0;
  always #5 isoClk = ~isoClk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge isoClk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic card);
    byteValid    = 1'b1;
    byteData     = d;
    byteFromCard = card;
    tick();
    byteValid    = 1'b0;
  endtask

  // Sends the top n bytes of w, MSB first, back to back
  task automatic send4(input logic [31:0] w, input int n, input logic card);
    for (int i = 0; i < n; i++)
      send(w[31-8*i -: 8], card);
  endtask

  task automatic do_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  task automatic push(input logic done, input logic err, input logic [2:0] code,
                      input logic [3:0] fi, input logic [3:0] di,
                      input logic [3:0] prot);
    exp_t e;
    e.done = done;
    e.err  = err;
    e.code = code;
    e.fi   = fi;
    e.di   = di;
    e.prot = prot;
    q_exp.push_back(e);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " active"}, ppsActive, 0);
    chk({tag, " done"}, ppsDone, 0);
    chk({tag, " error"}, ppsError, 0);
    chk({tag, " code"}, errCode, 0);
    chk({tag, " fi"}, negFiCode, 4'h1);
    chk({tag, " di"}, negDiCode, 4'h1);
    chk({tag, " prot"}, negProtocol, 0);
    chk({tag, " upd"}, fiDiUpdate, 0);
  endtask

  task automatic wait_result(input string tag);
    exp_t e;
    int   k;
    k = 0;
    while (!(ppsDone || ppsError) && k < 50) begin
      tick();
      k++;
    end
    chk({tag, " finished"}, ppsDone | ppsError, 1);
    if (q_exp.size() == 0) begin
      chk({tag, " scoreboard empty"}, 0, 1);
    end else begin
      e = q_exp.pop_front();
      chk({tag, " done"}, ppsDone, e.done);
      chk({tag, " error"}, ppsError, e.err);
      chk({tag, " code"}, errCode, e.code);
      chk({tag, " fi"}, negFiCode, e.fi);
      chk({tag, " di"}, negDiCode, e.di);
      chk({tag, " prot"}, negProtocol, e.prot);
      chk({tag, " active"}, ppsActive, 0);
      chk({tag, " upd"}, fiDiUpdate, e.done);
      tick();
      chk({tag, " upd one cycle"}, fiDiUpdate, 0);
      chk({tag, " held"}, {ppsDone, ppsError}, {e.done, e.err});
    end
  endtask

  logic [7:0] pck;

  initial begin
    n_chk        = 0;
    n_fail       = 0;
    nReset       = 1'b0;
    restart      = 1'b0;
    enable       = 1'b1;
    byteValid    = 1'b0;
    byteData     = 8'h00;
    byteFromCard = 1'b0;
    cyclesPerEtu = 13'd1;
    repeat (3) @(posedge isoClk);
    #1;
    check_reset("reset");
    nReset = 1'b1;
    tick();

    // Full PPS1 echo
    send(8'hFF, 0);
    chk("t1 active after PPSS", ppsActive, 1);
    send4(32'h10957A00, 3, 0);
    push(1, 0, 0, 4'h9, 4'h5, 4'h0);
    send4(32'hFF10957A, 4, 1);
    wait_result("t1");

    // Response drops PPS1: defaults stay
    do_restart();
    check_reset("t2 restart");
    send4(32'hFF10957A, 4, 0);
    push(1, 0, 0, 4'h1, 4'h1, 4'h0);
    send4(32'hFF00FF00, 3, 1);
    wait_result("t2");

    // Bad request PCK, later bytes ignored
    do_restart();
    push(0, 1, 3'd2, 4'h1, 4'h1, 4'h0);
    send4(32'hFF10957B, 4, 0);
    wait_result("t3");
    send4(32'hFF10957A, 4, 0);
    send(8'h3B, 1);
    chk("t3 sticky code", errCode, 3'd2);
    chk("t3 sticky error", ppsError, 1);

    // Response PPS0 mismatch
    do_restart();
    send4(32'hFF10957A, 4, 0);
    push(0, 1, 3'd5, 4'h1, 4'h1, 4'h0);
    send4(32'hFF110000, 2, 1);
    wait_result("t4");

    // Card byte during request, then restart wins over byteValid
    do_restart();
    push(0, 1, 3'd6, 4'h1, 4'h1, 4'h0);
    send(8'hFF, 0);
    send(8'h3B, 1);
    wait_result("t5");
    restart      = 1'b1;
    byteValid    = 1'b1;
    byteData     = 8'hFF;
    byteFromCard = 1'b0;
    tick();
    restart   = 1'b0;
    byteValid = 1'b0;
    check_reset("t5 restart+byte");
    tick();
    chk("t5 still idle", ppsActive, 0);

    // Trigger ignored while disabled
    enable = 1'b0;
    send(8'hFF, 0);
    chk("t6 disabled", ppsActive, 0);
    enable = 1'b1;

    // Reserved PPS0 bit
    push(0, 1, 3'd1, 4'h1, 4'h1, 4'h0);
    send4(32'hFF800000, 2, 0);
    wait_result("t7");

    // T=1 with PPS1=13
    do_restart();
    pck = 8'hFF ^ 8'h11 ^ 8'h13;
    send4({24'hFF1113, pck}, 4, 0);
    push(1, 0, 0, 4'h1, 4'h3, 4'h1);
    send4({24'hFF1113, pck}, 4, 1);
    wait_result("t8");

    // PPS2 only, echoed
    do_restart();
    pck = 8'hFF ^ 8'h20 ^ 8'hAA;
    send4({24'hFF20AA, pck}, 4, 0);
    push(1, 0, 0, 4'h1, 4'h1, 4'h0);
    send4({24'hFF20AA, pck}, 4, 1);
    wait_result("t9");

    // Bad response PPSS
    do_restart();
    send4(32'hFF10957A, 4, 0);
    push(0, 1, 3'd3, 4'h1, 4'h1, 4'h0);
    send(8'h00, 1);
    wait_result("t10");

    // Bad response PCK
    do_restart();
    send4(32'hFF10957A, 4, 0);
    push(0, 1, 3'd4, 4'h1, 4'h1, 4'h0);
    send4(32'hFF109500, 4, 1);
    wait_result("t11");

    // Terminal byte during response
    do_restart();
    send4(32'hFF10957A, 4, 0);
    push(0, 1, 3'd6, 4'h1, 4'h1, 4'h0);
    send(8'hFF, 0);
    wait_result("t12");

    // No response at all
    do_restart();
    send4(32'hFF10957A, 4, 0);
`ifdef PPS_TIMEOUT_EN
    begin
      int k;
      k = 0;
      while (!ppsError && k < 9700) begin
        tick();
        k++;
      end
      chk("t13 timeout error", ppsError, 1);
      chk("t13 timeout code", errCode, 3'd7);
      chk("t13 timeout window", (k >= 9595 && k <= 9605), 1);
    end
`else
    repeat (200) tick();
    chk("t13 still active", ppsActive, 1);
    chk("t13 no error", ppsError, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
